// File: rtl/mips_instr_encoder_if.sv
// Request/response bus for the MIPS instruction encoder.
// The master side supplies instruction fields and consumes encoded words.
// The slave side is the encoder itself.
interface mips_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    output out_ready,
    input  in_ready, out_valid, out_word, out_addr
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    input  out_ready,
    output in_ready, out_valid, out_word, out_addr
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: turns a class code plus register, immediate and
// target fields into a 32-bit machine word. Encoded words are queued in a
// 2-entry FIFO and presented together with their instruction-memory address,
// so a loader can stream them straight into IM.
module mips_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          ERR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  mips_instr_encoder_if.slave bus,
  output logic [15:0]       word_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_BEQ  = 5'd2,  OP_ORI  = 5'd3,
    OP_LUI  = 5'd4,  OP_LW   = 5'd5,  OP_SW   = 5'd6,  OP_ADDI = 5'd7,
    OP_SLL  = 5'd8,  OP_SLLV = 5'd9,  OP_SLT  = 5'd10, OP_J    = 5'd11,
    OP_JAL  = 5'd12, OP_JR   = 5'd13, OP_SB   = 5'd14, OP_LB   = 5'd15
  } op_e;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic [1:0]  count;
  logic [1:0]  count_after_pop;
  logic [31:0] entry0;
  logic [31:0] entry1;
  logic [31:0] addr;
  logic        accept;
  logic        push;
  logic        pop;

  // Handshake status comes from registered state only, so in_ready never
  // depends on out_ready and a full FIFO refuses input even while popping.
  assign bus.in_ready  = (count < 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_word  = entry0;
  assign bus.out_addr  = addr;

  assign accept          = bus.in_valid && bus.in_ready;
  assign push            = accept && enc_legal;
  assign pop             = bus.out_valid && bus.out_ready;
  assign count_after_pop = count - {1'b0, pop};

  // Assemble the machine word, forcing unused fields to zero per format.
  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (bus.in_op)
      OP_ADD:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h20};
      OP_SUB:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h22};
      OP_SLL:  enc_word = {6'h00, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h00};
      OP_SLLV: enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h04};
      OP_SLT:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h2A};
      OP_JR:   enc_word = {6'h00, bus.in_rs, 15'd0, 6'h08};
      OP_BEQ:  enc_word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_ORI:  enc_word = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_LUI:  enc_word = {6'h0F, 5'd0, bus.in_rt, bus.in_imm};
      OP_LW:   enc_word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_SW:   enc_word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_ADDI: enc_word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_SB:   enc_word = {6'h28, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_LB:   enc_word = {6'h20, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_J:    enc_word = {6'h02, bus.in_target};
      OP_JAL:  enc_word = {6'h03, bus.in_target};
      default: enc_legal = 1'b0;
    endcase
  end

  // Two-entry shift FIFO: entry0 is the head; a push lands in the first
  // free slot left after any same-cycle pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= 2'd0;
      entry0 <= 32'd0;
      entry1 <= 32'd0;
    end else begin
      if (pop) begin
        entry0 <= entry1;
      end
      if (push) begin
        if (count_after_pop == 2'd0) begin
          entry0 <= enc_word;
        end else begin
          entry1 <= enc_word;
        end
      end
      count <= count_after_pop + {1'b0, push};
    end
  end

  // Target address and popped-word count advance together on every pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr     <= BASE_ADDR;
      word_cnt <= 16'd0;
    end else if (pop) begin
      addr     <= addr + 32'd4;
      word_cnt <= word_cnt + 16'd1;
    end
  end

  // Count accepted illegal codes, saturating so the counter never wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (accept && !enc_legal && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the single-cycle CPU's instruction decoder. Takes an instruction class code plus register/immediate fields and assembles the 32-bit MIPS machine word.
- Buffers encoded words in a 2-entry FIFO and emits them with target addresses for loading instruction memory, e.g. by a test harness or boot loader ahead of the CPU's IM.
- Covers the same 16 instructions the CPU control path supports.

Parameters:
- BASE_ADDR, 32'h0000_3000, address of the first emitted word.
- ERR_W, 8, width of the illegal-code counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; state clears on a clk edge while reset==0.
- in_valid  in  1  request carries an instruction.
- in_ready  out  1  block can accept a request this cycle.
- in_op  in  5  class code: 0 add, 1 sub, 2 beq, 3 ori, 4 lui, 5 lw, 6 sw, 7 addi, 8 sll, 9 sllv, 10 slt, 11 j, 12 jal, 13 jr, 14 sb, 15 lb; 16-31 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_shamt  in  5  shift amount (sll only).
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target field.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes the head word.
- out_word  out  32  encoded head instruction.
- out_addr  out  32  address of the head word.
- word_cnt  out  16  words popped since reset.
- err_cnt  out  ERR_W  illegal codes seen since reset.

Behaviour:
- Reset values: FIFO empty, out_valid=0, out_word=0, out_addr=BASE_ADDR, word_cnt=0, err_cnt=0. in_ready=1 as soon as reset deasserts.
- Reset mid-operation discards all buffered words.
- Accept occurs when in_valid&&in_ready. in_ready = (count<2) and depends only on registered count, with no path from out_ready.
- When full, an accept is refused even if a pop happens the same cycle.
- Encoding is combinational at accept; the word is registered into the FIFO. Latency: accepted in cycle N, visible on out_word/out_valid in cycle N+1 when the FIFO was empty.
- R-type (op field=0): rs|rt|rd|shamt|funct. Functs: add 0x20, sub 0x22, sll 0x00, sllv 0x04, slt 0x2A, jr 0x08.
  - shamt field forced 0 except for sll.
  - sll forces rs=0.
  - jr forces rt=rd=shamt=0.
- I-type: op|rs|rt|imm. Opcodes: beq 0x04, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, addi 0x08, sb 0x28, lb 0x20. lui forces rs=0.
- J-type: op|target. Opcodes: j 0x02, jal 0x03.
- Illegal in_op (>=16):
  - Accepted, so in_ready behaves normally, but nothing is pushed.
  - err_cnt increments, saturating at all-ones.
- FIFO:
  - 2 entries, head-first.
  - out_valid = (count>0); out_word = head entry.
  - Pop on out_valid&&out_ready.
  - Simultaneous push and pop at count 1 leaves count 1, and the new word becomes head next cycle.
  - out_word holds stable while out_valid&&!out_ready.
- Address: out_addr is BASE_ADDR + 4*word_cnt (a register, not a multiplier). It advances by 4 on each pop and wraps modulo 2^32.
- word_cnt increments on each pop and wraps at 16 bits.
- Popping from empty is impossible: out_valid gates it.

Test Plan:
- Reset, then addi rs=0 rt=8 imm=5 with out_ready=1: next cycle out_word=0x20080005, out_addr=0x00003000. Following cycle out_valid=0, word_cnt=1.
- Back-to-back add(rs1,rt2,rd3), sll(rt2,rd4,shamt3, rs=7 applied), jr(rs31, junk rt/rd) with out_ready=1: words 0x00221820, 0x000220C0, 0x03E00008 at addresses 0x3000, 0x3004, 0x3008. Forced-zero fields are verified.
- out_ready=0, push ori rt1 imm 0xFFFF then lui rt2 imm 0x1234 (rs=5): in_ready drops to 0 after 2nd accept and out_word holds 0x3401FFFF. Raise out_ready: words pop in order, then 0x3C021234; in_ready returns to 1 the cycle after the first pop.
- jal target 0x0000C03, then sw rt1 imm 4: 0x0C000C03, 0xAC010004. With in_op=20 in between, no word is emitted, err_cnt=1, and out_addr sequence is unbroken.
- Full FIFO, assert reset=0 for one cycle with in_valid=1: out_valid=0, out_addr=0x3000, word_cnt=0, err_cnt=0. The first post-reset word appears at 0x3000.
- Wrap: BASE_ADDR=32'hFFFF_FFFC, push 2 words: out_addr 0xFFFFFFFC then 0x00000000. Push 300 illegal codes: err_cnt saturates at 0xFF.
